// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling message sequencer: state encoding,
// nibble width and the default step-period calculation.
package scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HOLD   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    localparam int NIBBLE_W = 4;

    // Widened so that FREQ*DELAY_MS does not overflow 32 bits.
    function automatic int default_delay(input int freq, input int delay_ms);
        longint prod;
        prod = longint'(freq) * longint'(delay_ms);
        return int'(prod / 1000);
    endfunction

endpackage

// File: rtl/scroll_ctrl_step_timer.sv
// Step-period counter: counts 0..DELAY-1 while enabled, holds while disabled,
// and flags the terminal count combinationally so the caller acts on that edge.
module step_timer
    import scroll_pkg::*;
#(
    parameter int DELAY = 4
) (
    input  logic i_clk,
    input  logic i_rst_neg,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign o_term = i_en && (cnt_q == CNT_W'(DELAY - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_neg) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= o_term ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// Message scroll sequencer: owns the rotating hex buffer, dwells after each
// wrap-around, supports pause/resume and exposes the leftmost window to multi7.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int DISPLAYS   = 4,
    parameter int DIGITS     = 18,
    parameter int FREQ       = 27_000_000,
    parameter int DELAY_MS   = 300,
    parameter int DELAY      = default_delay(FREQ, DELAY_MS),
    parameter int HOLD_STEPS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_neg,
    input  logic                         i_load,
    input  logic [4*DIGITS-1:0]          i_message,
    input  logic                         i_pause,
    input  logic                         i_dir,
    output logic [4*DISPLAYS-1:0]        o_window,
    output logic [$clog2(DIGITS)-1:0]    o_offset,
    output logic                         o_step,
    output logic                         o_wrap,
    output logic [1:0]                   o_state
);

    localparam int MSG_W  = NIBBLE_W * DIGITS;
    localparam int WIN_W  = NIBBLE_W * DISPLAYS;
    localparam int OFF_W  = $clog2(DIGITS);
    localparam int HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;

    logic [MSG_W-1:0]  buf_q, buf_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    state_t            state_q, state_d;
    state_t            saved_q, saved_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;

    logic              timer_en;
    logic              step_evt;
    logic [OFF_W-1:0]  off_step;
    logic [HOLD_W-1:0] hold_inc;

    // The period only advances while actively scrolling or dwelling.
    assign timer_en = (state_q == ST_SCROLL) || (state_q == ST_HOLD);

    step_timer #(
        .DELAY (DELAY)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_neg (i_rst_neg),
        .i_clr     (i_load),
        .i_en      (timer_en),
        .o_term    (step_evt)
    );

    assign hold_inc = hold_q + 1'b1;

    always_comb begin
        buf_d    = buf_q;
        off_d    = off_q;
        hold_d   = hold_q;
        state_d  = state_q;
        saved_d  = saved_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        off_step = off_q;

        if (i_load) begin
            buf_d   = i_message;
            off_d   = '0;
            hold_d  = '0;
            state_d = ST_SCROLL;
        end else begin
            case (state_q)
                ST_SCROLL: begin
                    if (step_evt) begin
                        if (!i_dir) begin
                            buf_d    = {buf_q[MSG_W-NIBBLE_W-1:0], buf_q[MSG_W-1 -: NIBBLE_W]};
                            off_step = (off_q == OFF_W'(DIGITS - 1)) ? '0 : off_q + 1'b1;
                        end else begin
                            buf_d    = {buf_q[NIBBLE_W-1:0], buf_q[MSG_W-1:NIBBLE_W]};
                            off_step = (off_q == '0) ? OFF_W'(DIGITS - 1) : off_q - 1'b1;
                        end
                        off_d  = off_step;
                        step_d = 1'b1;
                        if (off_step == '0) begin
                            wrap_d = 1'b1;
                            if (HOLD_STEPS > 0) begin
                                state_d = ST_HOLD;
                                hold_d  = '0;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (step_evt) begin
                        if (hold_inc == HOLD_W'(HOLD_STEPS)) begin
                            state_d = ST_SCROLL;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
                default: ;
            endcase

            // Pause is evaluated after any step so a coincident step is kept.
            if (i_pause) begin
                if (state_q == ST_SCROLL || state_q == ST_HOLD) begin
                    saved_d = state_d;
                    state_d = ST_PAUSED;
                end else if (state_q == ST_PAUSED) begin
                    state_d = saved_q;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_neg) begin
            buf_q   <= '0;
            off_q   <= '0;
            hold_q  <= '0;
            state_q <= ST_IDLE;
            saved_q <= ST_IDLE;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            off_q   <= off_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            saved_q <= saved_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_window = buf_q[MSG_W-1 -: WIN_W];
    assign o_offset = off_q;
    assign o_step   = step_q;
    assign o_wrap   = wrap_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl with DIGITS=6, DISPLAYS=4, DELAY=4, HOLD_STEPS=2.
module tb_scroll_ctrl;

    localparam int DIGITS     = 6;
    localparam int DISPLAYS   = 4;
    localparam int DELAY      = 4;
    localparam int HOLD_STEPS = 2;
    localparam int OFF_W      = $clog2(DIGITS);

    logic                      clk;
    logic                      rst_n;
    logic                      load;
    logic [4*DIGITS-1:0]       message;
    logic                      pause;
    logic                      dir;
    logic [4*DISPLAYS-1:0]     window;
    logic [OFF_W-1:0]          offset;
    logic                      step;
    logic                      wrap;
    logic [1:0]                state;

    int n_cmp = 0;
    int n_err = 0;

    scroll_ctrl #(
        .DISPLAYS   (DISPLAYS),
        .DIGITS     (DIGITS),
        .FREQ       (27_000_000),
        .DELAY_MS   (300),
        .DELAY      (DELAY),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .i_clk     (clk),
        .i_rst_neg (rst_n),
        .i_load    (load),
        .i_message (message),
        .i_pause   (pause),
        .i_dir     (dir),
        .o_window  (window),
        .o_offset  (offset),
        .o_step    (step),
        .o_wrap    (wrap),
        .o_state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 'h%0h", tag, got);
        end
    endtask

    // Advance n edges, leaving the bench 1 time unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load();
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    logic [15:0] left_win [0:6];
    int cnt;

    initial begin
        left_win[0] = 16'h1234;
        left_win[1] = 16'h2345;
        left_win[2] = 16'h3456;
        left_win[3] = 16'h4561;
        left_win[4] = 16'h5612;
        left_win[5] = 16'h6123;
        left_win[6] = 16'h1234;

        rst_n   = 1'b0;
        load    = 1'b0;
        pause   = 1'b0;
        dir     = 1'b0;
        message = 24'h123456;
        cyc(2);
        rst_n = 1'b1;

        // 1: idle after reset
        chk_eq("rst_window", 32'(window), 32'h0000);
        chk_eq("rst_state", 32'(state), 32'd0);
        chk_eq("rst_offset", 32'(offset), 32'd0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (step || wrap) cnt++;
        end
        chk_eq("idle_no_steps", 32'(cnt), 32'd0);

        // 2: left rotation through a full wrap and dwell
        dir = 1'b0;
        do_load();
        chk_eq("load_window", 32'(window), 32'h1234);
        chk_eq("load_state", 32'(state), 32'd1);
        cyc(3);
        chk_eq("pre_step", 32'(step), 32'd0);
        cyc(1);
        chk_eq("step1_pulse", 32'(step), 32'd1);
        chk_eq("step1_window", 32'(window), 32'h2345);
        chk_eq("step1_offset", 32'(offset), 32'd1);
        for (int k = 2; k <= 6; k++) begin
            cyc(4);
            chk_eq($sformatf("left_win_k%0d", k), 32'(window), 32'(left_win[k]));
            chk_eq($sformatf("left_off_k%0d", k), 32'(offset), 32'(k % DIGITS));
            chk_eq($sformatf("left_wrap_k%0d", k), 32'(wrap), (k == 6) ? 32'd1 : 32'd0);
        end
        chk_eq("wrap_state_hold", 32'(state), 32'd2);
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            chk_eq($sformatf("hold_frozen_%0d", i), 32'({wrap, step, state, window}), 32'({1'b0, 1'b0, 2'd2, 16'h1234}));
        end
        cyc(1);
        chk_eq("hold_exit_state", 32'(state), 32'd1);
        chk_eq("hold_exit_nostep", 32'(step), 32'd0);
        cyc(4);
        chk_eq("post_hold_step", 32'(step), 32'd1);
        chk_eq("post_hold_window", 32'(window), 32'h2345);

        // 3: right rotation then direction change
        dir = 1'b1;
        do_load();
        cyc(4);
        chk_eq("right_window", 32'(window), 32'h6123);
        chk_eq("right_offset", 32'(offset), 32'd5);
        chk_eq("right_nowrap", 32'(wrap), 32'd0);
        cyc(2);
        dir = 1'b0;
        cyc(2);
        chk_eq("back_window", 32'(window), 32'h1234);
        chk_eq("back_offset", 32'(offset), 32'd0);
        chk_eq("back_wrap", 32'(wrap), 32'd1);
        cyc(1);
        chk_eq("back_wrap_gone", 32'(wrap), 32'd0);

        // 4: pause mid-period, resume completes the remaining period
        dir = 1'b0;
        do_load();
        cyc(1);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk_eq("paused_state", 32'(state), 32'd3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step || window != 16'h1234 || state != 2'd3) cnt++;
        end
        chk_eq("paused_frozen", 32'(cnt), 32'd0);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk_eq("resume_state", 32'(state), 32'd1);
        chk_eq("resume_nostep0", 32'(step), 32'd0);
        cyc(1);
        chk_eq("resume_nostep1", 32'(step), 32'd0);
        cyc(1);
        chk_eq("resume_step", 32'(step), 32'd1);
        chk_eq("resume_window", 32'(window), 32'h2345);

        // 5: pause on the step edge, then load overrides pause
        cyc(3);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk_eq("pstep_pulse", 32'(step), 32'd1);
        chk_eq("pstep_window", 32'(window), 32'h3456);
        chk_eq("pstep_state", 32'(state), 32'd3);
        cyc(1);
        chk_eq("pstep_nostep", 32'(step), 32'd0);
        load  = 1'b1;
        pause = 1'b1;
        cyc(1);
        load  = 1'b0;
        pause = 1'b0;
        chk_eq("lp_state", 32'(state), 32'd1);
        chk_eq("lp_window", 32'(window), 32'h1234);
        chk_eq("lp_offset", 32'(offset), 32'd0);
        cyc(4);
        chk_eq("lp_step_runs", 32'(window), 32'h2345);

        // 6: reset during HOLD
        cyc(20);
        chk_eq("pre_rst_state", 32'(state), 32'd2);
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk_eq("mid_rst_state", 32'(state), 32'd0);
        chk_eq("mid_rst_offset", 32'(offset), 32'd0);
        chk_eq("mid_rst_window", 32'(window), 32'h0000);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (wrap || step) cnt++;
        end
        chk_eq("post_rst_quiet", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
